// File: rtl/aes_pkg.sv
// Shared AES constants: round constants, S-box and scheduler state encoding.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StEmit
    } state_e;

    // Padded to 16 entries so any 4-bit round index is in range; only 1..10 are meaningful.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] rcon_word(input logic [3:0] round);
        return {RCON[round], 24'h0};
    endfunction

endpackage

// File: rtl/aes_rot_sub_word.sv
// Combinational RotWord followed by SubWord on one 32-bit key word.
module aes_rot_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {SBOX[word_i[23:16]], SBOX[word_i[15:8]],
                     SBOX[word_i[7:0]],   SBOX[word_i[31:24]]};

endmodule

// File: rtl/inverse_key_scheduler.sv
// AES-128 inverse key schedule: streams round keys 10 down to 0 from a single key register.
// Define INVKEY_FWD_EN to accept the cipher key and expand it forward to round 10 first.
module inverse_key_scheduler
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;

    logic [31:0] c0, c1, c2, c3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rs_in, rs_out;

    assign c0 = key_q[127:96];
    assign c1 = key_q[95:64];
    assign c2 = key_q[63:32];
    assign c3 = key_q[31:0];

    // Undo the chained XOR first so RotSub sees the recovered last word of round r-1.
    assign p3 = c3 ^ c2;
    assign p2 = c2 ^ c1;
    assign p1 = c1 ^ c0;
    assign p0 = c0 ^ rcon_word(round_q) ^ rs_out;

`ifdef INVKEY_FWD_EN
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] f0, f1, f2, f3;

    assign f0    = c0 ^ rs_out ^ rcon_word(cnt_q);
    assign f1    = c1 ^ f0;
    assign f2    = c2 ^ f1;
    assign f3    = c3 ^ f2;
    assign rs_in = (state_q == StFwd) ? c3 : p3;
`else
    assign rs_in = p3;
`endif

    aes_rot_sub_word u_rot_sub (
        .word_i (rs_in),
        .word_o (rs_out)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
`ifdef INVKEY_FWD_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    key_d = key_in;
`ifdef INVKEY_FWD_EN
                    state_d = StFwd;
                    cnt_d   = 4'd1;
`else
                    state_d = StEmit;
                    round_d = NR[3:0];
`endif
                end
            end
`ifdef INVKEY_FWD_EN
            StFwd: begin
                key_d = {f0, f1, f2, f3};
                if (cnt_q == NR[3:0]) begin
                    state_d = StEmit;
                    round_d = NR[3:0];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            StEmit: begin
                if (rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        key_d   = {p0, p1, p2, p3};
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

`ifdef INVKEY_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign key_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rk_valid  = (state_q == StEmit);
    assign rk_last   = rk_valid && (round_q == 4'd0);
    assign rk_out    = key_q;
    assign rk_round  = round_q;

endmodule

// File: tb/tb_inverse_key_scheduler.sv
// Directed bench for inverse_key_scheduler using FIPS-197 A.1 round keys.
module tb_inverse_key_scheduler;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef INVKEY_FWD_EN
    localparam logic [127:0] LOAD_KEY = K0;
    localparam int           LAT      = 11;
`else
    localparam logic [127:0] LOAD_KEY = K10;
    localparam int           LAT      = 1;
`endif

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;

    vec_t tbl [11];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic         rk_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inverse_key_scheduler #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge; waits for the first round key.
    task automatic wait_first();
        int lat;
        lat = 1;
        chk("busy_after_load", busy, 1'b1);
        chk("no_ready_after_load", key_ready, 1'b0);
        while (!rk_valid && lat < 40) begin
            chk("busy_in_fwd", busy, 1'b1);
            chk("no_ready_in_fwd", key_ready, 1'b0);
            @(negedge clk);
            lat++;
        end
        chk("first_key_latency", lat, LAT);
    endtask

    task automatic load(input bit hold);
        @(negedge clk);
        key_in    = LOAD_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        if (!hold) key_valid = 1'b0;
        wait_first();
    endtask

    // Expects rk_ready high; checks all 11 keys then the return to idle.
    task automatic stream();
        for (int i = 0; i < 11; i++) begin
            chk("rk_valid", rk_valid, 1'b1);
            chk($sformatf("rk_out_r%0d", tbl[i].round), rk_out, tbl[i].key);
            chk("rk_round", rk_round, tbl[i].round);
            chk("rk_last", rk_last, (i == 10));
            @(negedge clk);
        end
        chk("end_valid_low", rk_valid, 1'b0);
        chk("end_key_ready", key_ready, 1'b1);
        chk("end_busy_low", busy, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{4'd10, K10};
        tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[10] = '{4'd0,  K0};

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_out", rk_out, 128'h0);
        chk("rst_round", rk_round, 4'd0);
        chk("rst_key_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", rk_last, 1'b0);

        // Full-rate stream
        load(1'b0);
        stream();

        // Random stalls with ignored mid-stream key pulses
        load(1'b0);
        for (int i = 0; i < 11; i++) begin
            int nst;
            nst = $urandom_range(0, 2);
            for (int s = 0; s < nst; s++) begin
                rk_ready  = 1'b0;
                key_valid = 1'b1;
                key_in    = 128'hdeadbeef_00000000_cafef00d_12345678;
                @(negedge clk);
                chk("stall_valid", rk_valid, 1'b1);
                chk("stall_out", rk_out, tbl[i].key);
                chk("stall_round", rk_round, tbl[i].round);
                chk("stall_key_ready", key_ready, 1'b0);
            end
            key_valid = 1'b0;
            rk_ready  = 1'b1;
            chk("stall_accept_out", rk_out, tbl[i].key);
            chk("stall_accept_last", rk_last, (i == 10));
            @(negedge clk);
        end
        chk("stall_end_valid", rk_valid, 1'b0);
        chk("stall_end_ready", key_ready, 1'b1);

        // Asynchronous reset while round 5 is presented
        load(1'b0);
        repeat (5) @(negedge clk);
        chk("pre_rst_round", rk_round, 4'd5);
        chk("pre_rst_out", rk_out, tbl[5].key);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", rk_valid, 1'b0);
        chk("abort_out", rk_out, 128'h0);
        chk("abort_round", rk_round, 4'd0);
        chk("abort_key_ready", key_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load(1'b0);
        stream();

        // Back-to-back loads with key_valid held high
        load(1'b1);
        stream();
        @(negedge clk);
        wait_first();
        key_valid = 1'b0;
        stream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
